// File: rtl/free_list.sv
// Circular free list of physical register tags for the rename stage.
// Grants up to two tags and accepts up to two releases per cycle; marks allocated tags busy one cycle later.
module free_list #(
    parameter int PHY_RF_DEPTH  = 64,
    parameter int ARCH_RF_DEPTH = 32,
    parameter int FL_DEPTH      = PHY_RF_DEPTH - ARCH_RF_DEPTH,
    localparam int TW           = $clog2(PHY_RF_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc1_req,
    input  logic          alloc2_req,
    output logic          alloc_ready,
    output logic [TW-1:0] alloc1_tag,
    output logic [TW-1:0] alloc2_tag,
    input  logic          rel1_en,
    input  logic [TW-1:0] rel1_tag,
    input  logic          rel2_en,
    input  logic [TW-1:0] rel2_tag,
    output logic          bt_wr1_en,
    output logic [TW-1:0] bt_wr1_addr,
    output logic          bt_wr1_in,
    output logic          bt_wr2_en,
    output logic [TW-1:0] bt_wr2_addr,
    output logic          bt_wr2_in,
    output logic [TW:0]   free_count,
    output logic          overflow_err
);

    localparam int IW = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
    localparam int CW = TW + 1;

    logic [TW-1:0] entries [FL_DEPTH];
    logic [IW-1:0] head, tail;
    logic [IW-1:0] head_p1, head_p2, tail_p1, tail_p2, rel2_idx;
    logic [CW-1:0] count, base;
    logic [1:0]    n_req, granted, accepted;
    logic          grant, rel1_ok, rel2_ok;

    // Pointer increment that wraps at FL_DEPTH-1 even when the depth is not a power of two.
    function automatic logic [IW-1:0] inc(input logic [IW-1:0] p);
        return (p == IW'(FL_DEPTH - 1)) ? '0 : p + IW'(1);
    endfunction

    assign head_p1 = inc(head);
    assign head_p2 = inc(head_p1);
    assign tail_p1 = inc(tail);
    assign tail_p2 = inc(tail_p1);

    assign n_req       = {1'b0, alloc1_req} + {1'b0, alloc2_req};
    assign alloc_ready = (count >= CW'(n_req));
    assign grant       = alloc_ready && (n_req != 2'd0);
    assign granted     = grant ? n_req : 2'd0;

    assign alloc1_tag = entries[head];
    assign alloc2_tag = alloc1_req ? entries[head_p1] : entries[head];

    // Releases see room freed by this cycle's grant, and rel2 also sees rel1's push.
    assign base     = count - CW'(granted);
    assign rel1_ok  = rel1_en && (base < CW'(FL_DEPTH));
    assign rel2_ok  = rel2_en && ((base + CW'(rel1_ok)) < CW'(FL_DEPTH));
    assign accepted = {1'b0, rel1_ok} + {1'b0, rel2_ok};
    assign rel2_idx = rel1_en ? tail_p1 : tail;

    assign free_count = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                entries[i] <= TW'(ARCH_RF_DEPTH + i);
            end
            head         <= '0;
            tail         <= '0;
            count        <= CW'(FL_DEPTH);
            overflow_err <= 1'b0;
            bt_wr1_en    <= 1'b0;
            bt_wr1_addr  <= '0;
            bt_wr1_in    <= 1'b0;
            bt_wr2_en    <= 1'b0;
            bt_wr2_addr  <= '0;
            bt_wr2_in    <= 1'b0;
        end else begin
            if (rel1_ok) entries[tail]     <= rel1_tag;
            if (rel2_ok) entries[rel2_idx] <= rel2_tag;

            case (granted)
                2'd1:    head <= head_p1;
                2'd2:    head <= head_p2;
                default: head <= head;
            endcase

            case (accepted)
                2'd1:    tail <= tail_p1;
                2'd2:    tail <= tail_p2;
                default: tail <= tail;
            endcase

            count        <= count - CW'(granted) + CW'(accepted);
            overflow_err <= overflow_err | (rel1_en & ~rel1_ok) | (rel2_en & ~rel2_ok);

            // Address and data hold between grants; only the enables drop.
            if (grant) begin
                bt_wr1_en   <= alloc1_req;
                bt_wr1_addr <= alloc1_tag;
                bt_wr1_in   <= 1'b1;
                bt_wr2_en   <= alloc2_req;
                bt_wr2_addr <= alloc2_tag;
                bt_wr2_in   <= 1'b1;
            end else begin
                bt_wr1_en <= 1'b0;
                bt_wr2_en <= 1'b0;
            end
        end
    end

endmodule
